// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder
//   Upstream stage of the UART transmitter. Host-written characters are
//   buffered in a DEPTH-entry FIFO, or in a single holding register when FIFO
//   mode is off. Each character is formatted into a 9-bit word: data bits
//   masked to the word length, with the parity bit placed just above them.
//   The block issues one start pulse per frame and waits for the transmitter's
//   end-of-frame pulse before it starts the next frame.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    host THR write strobe and character
//   fifo_en           1 = FIFO of DEPTH entries, 0 = single holding register
//   fifo_clr          pulse; flushes buffered characters
//   word_length       data bits = 5 + word_length
//   parity_en, even_parity, stick_parity   line control parity setup
//   po_flag           end-of-frame pulse from the transmitter
//   pi_tx_data        formatted word, held stable for the whole frame
//   pi_flag           one-cycle frame start pulse
//   tx_count          characters currently buffered
//   thre, temt        buffer empty / buffer empty and transmitter idle
//   wr_drop           one-cycle pulse when a write hit a full buffer
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in flight; pops the head as soon as tx_count > 0
// SEND  | frame in flight; waits for po_flag, pi_tx_data held stable
module tx_fifo_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              fifo_en,
  input  logic              fifo_clr,
  input  logic [1:0]        word_length,
  input  logic              parity_en,
  input  logic              even_parity,
  input  logic              stick_parity,
  input  logic              po_flag,
  output logic [8:0]        pi_tx_data,
  output logic              pi_flag,
  output logic [ADDR_W:0]   tx_count,
  output logic              thre,
  output logic              temt,
  output logic              wr_drop
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                fifo_en_q;

  logic                flush;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [ADDR_W:0]     capacity;
  logic [ADDR_W:0]     count_nxt;
  logic [7:0]          head;

  // Mask to the word length, then put the parity bit directly above the data.
  function automatic logic [8:0] format_word(input logic [7:0] d,
                                             input logic [1:0] wl,
                                             input logic       pen,
                                             input logic       ep,
                                             input logic       sp);
    logic [7:0] mask;
    logic [7:0] m;
    logic       par;
    logic [8:0] w;
    mask = 8'hFF >> (2'd3 - wl);
    m    = d & mask;
    par  = sp ? ~ep : (ep ? ^m : ~^m);
    w    = {1'b0, m};
    if (pen && par) begin
      w = w | (9'd1 << (4'd5 + {2'b00, wl}));
    end
    return w;
  endfunction

  always_comb begin
    // Toggling FIFO mode changes the buffer geometry, so treat it as a flush.
    flush    = fifo_clr | (fifo_en ^ fifo_en_q);
    capacity = fifo_en ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(1);
    full     = (tx_count >= capacity);
    pop      = (state == IDLE) && (tx_count != '0) && !flush;
    // A pop in the same cycle frees a slot, so a write at full is still taken.
    push     = wr_en && !flush && (!full || pop);
    drop     = wr_en && !flush && full && !pop;
    head     = mem[rd_ptr];

    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = tx_count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end

    state_nxt = state;
    case (state)
      IDLE: if (pop)     state_nxt = SEND;
      SEND: if (po_flag) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_en_q  <= 1'b0;
      tx_count   <= '0;
      pi_tx_data <= '0;
      pi_flag    <= 1'b0;
      thre       <= 1'b1;
      temt       <= 1'b1;
      wr_drop    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fifo_en_q <= fifo_en;
      tx_count  <= count_nxt;
      wr_drop   <= drop;
      pi_flag   <= 1'b0;
      thre      <= (count_nxt == '0);
      temt      <= (count_nxt == '0) && (state_nxt == IDLE);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      // Line control is captured only here, so mid-frame changes are ignored.
      if (pop) begin
        pi_tx_data <= format_word(head, word_length, parity_en,
                                  even_parity, stick_parity);
        pi_flag    <= 1'b1;
      end
    end
  end

endmodule
